// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - next-PC sequencing controller with redirect hold and squash cycles
// Optional performance counters are built when FETCH_SEQ_PERF_CNT_EN is defined.
module fetch_sequencer #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Br_AND,
    input  logic        JumpOr,
    input  logic [31:0] Br_ADD,
    input  logic [31:0] JumpMux,
    output logic        PC_En,
    output logic [1:0]  PC_Sel,
    output logic [31:0] Redirect_PC,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic [31:0] Fetch_Cnt,
    output logic [31:0] Stall_Cnt,
    output logic [31:0] Flush_Cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [3:0] LP_RELOAD         = 4'(FLUSH_CYCLES - 1);
    localparam state_t     LP_AFTER_REDIRECT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t      r_state, w_next_state;
    logic        r_pend_valid, w_next_pend;
    logic [31:0] r_redirect_pc;
    logic [3:0]  r_flush_ctr, w_next_ctr;
    logic        w_live, w_capture, w_issue;
    logic [1:0]  w_live_sel;
    logic [31:0] w_live_tgt;
    logic        w_pc_en, w_ifid_write, w_ifid_flush;
    logic [1:0]  w_pc_sel;

    // Older instruction (branch) wins over a simultaneous jump.
    assign w_live     = Br_AND | JumpOr;
    assign w_live_sel = Br_AND ? 2'b01 : 2'b10;
    assign w_live_tgt = Br_AND ? Br_ADD : JumpMux;

    always_comb begin
        w_pc_en      = 1'b0;
        w_pc_sel     = 2'b00;
        w_ifid_write = 1'b0;
        w_ifid_flush = 1'b0;
        w_next_state = r_state;
        w_next_pend  = r_pend_valid;
        w_next_ctr   = r_flush_ctr;
        w_capture    = 1'b0;
        w_issue      = 1'b0;
        if (Stall) begin
            w_next_state = HOLD;
            if (w_live && !r_pend_valid) begin
                w_capture   = 1'b1;
                w_next_pend = 1'b1;
            end
        end else begin
            w_pc_en      = 1'b1;
            w_ifid_write = 1'b1;
            if (w_live || (r_state == HOLD && r_pend_valid)) begin
                w_pc_sel     = w_live ? w_live_sel : 2'b11;
                w_ifid_flush = 1'b1;
                w_issue      = 1'b1;
                w_next_pend  = 1'b0;
                w_next_state = LP_AFTER_REDIRECT;
                w_next_ctr   = LP_RELOAD;
            end else if (r_state != RUN && r_flush_ctr != 4'd0) begin
                // Squash continues (also when resuming a flush interrupted by a stall).
                w_ifid_flush = 1'b1;
                w_next_ctr   = r_flush_ctr - 4'd1;
                w_next_state = (r_flush_ctr == 4'd1) ? RUN : FLUSH;
            end else begin
                w_next_state = RUN;
            end
        end
        if (Rst) begin
            w_pc_en      = 1'b0;
            w_pc_sel     = 2'b00;
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state       <= RUN;
            r_pend_valid  <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_flush_ctr   <= 4'd0;
        end else begin
            r_state      <= w_next_state;
            r_pend_valid <= w_next_pend;
            r_flush_ctr  <= w_next_ctr;
            if (w_capture) begin
                r_redirect_pc <= w_live_tgt;
            end
        end
    end

    assign PC_En       = w_pc_en;
    assign PC_Sel      = w_pc_sel;
    assign IFID_Write  = w_ifid_write;
    assign IFID_Flush  = w_ifid_flush;
    assign Redirect_PC = r_redirect_pc;

`ifdef FETCH_SEQ_PERF_CNT_EN
    logic [31:0] r_fetch_cnt, r_stall_cnt, r_flush_cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_pc_en) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (Stall)   r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_issue) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign Fetch_Cnt = r_fetch_cnt;
    assign Stall_Cnt = r_stall_cnt;
    assign Flush_Cnt = r_flush_cnt;
`else
    assign Fetch_Cnt = 32'd0;
    assign Stall_Cnt = 32'd0;
    assign Flush_Cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - bench for fetch_sequencer, FLUSH_CYCLES=1 and FLUSH_CYCLES=3 instances
module tb_fetch_sequencer;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Stall = 1'b0;
    logic        Br_AND = 1'b0;
    logic        JumpOr = 1'b0;
    logic [31:0] Br_ADD = 32'd0;
    logic [31:0] JumpMux = 32'd0;

    logic        d1_en, d3_en, d1_w, d3_w, d1_f, d3_f;
    logic [1:0]  d1_sel, d3_sel;
    logic [31:0] d1_rpc, d3_rpc, d1_fc, d3_fc, d1_sc, d3_sc, d1_xc, d3_xc;

    fetch_sequencer #(.FLUSH_CYCLES(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Br_AND(Br_AND), .JumpOr(JumpOr),
        .Br_ADD(Br_ADD), .JumpMux(JumpMux), .PC_En(d1_en), .PC_Sel(d1_sel),
        .Redirect_PC(d1_rpc), .IFID_Write(d1_w), .IFID_Flush(d1_f),
        .Fetch_Cnt(d1_fc), .Stall_Cnt(d1_sc), .Flush_Cnt(d1_xc)
    );

    fetch_sequencer #(.FLUSH_CYCLES(3)) u_dut3 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Br_AND(Br_AND), .JumpOr(JumpOr),
        .Br_ADD(Br_ADD), .JumpMux(JumpMux), .PC_En(d3_en), .PC_Sel(d3_sel),
        .Redirect_PC(d3_rpc), .IFID_Write(d3_w), .IFID_Flush(d3_f),
        .Fetch_Cnt(d3_fc), .Stall_Cnt(d3_sc), .Flush_Cnt(d3_xc)
    );

    always #5 Clk = ~Clk;

    logic [1:0]  a_en, a_w, a_f;
    logic [1:0]  a_sel [2];
    logic [31:0] a_rpc [2];
    logic [31:0] a_fc  [2];
    logic [31:0] a_sc  [2];
    logic [31:0] a_xc  [2];
    assign a_en = {d3_en, d1_en};
    assign a_w  = {d3_w, d1_w};
    assign a_f  = {d3_f, d1_f};
    assign a_sel[0] = d1_sel; assign a_sel[1] = d3_sel;
    assign a_rpc[0] = d1_rpc; assign a_rpc[1] = d3_rpc;
    assign a_fc[0]  = d1_fc;  assign a_fc[1]  = d3_fc;
    assign a_sc[0]  = d1_sc;  assign a_sc[1]  = d3_sc;
    assign a_xc[0]  = d1_xc;  assign a_xc[1]  = d3_xc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a pending target, remaining squash cycles, and event counts.
    logic        m_pv    [2];
    logic [31:0] m_pc    [2];
    int          m_sq    [2];
    logic [31:0] m_fetch [2];
    logic [31:0] m_stall [2];
    logic [31:0] m_flush [2];

    logic        e_en  [2];
    logic        e_w   [2];
    logic        e_f   [2];
    logic [1:0]  e_sel [2];
    logic [31:0] e_rpc [2];
    logic [31:0] e_fc  [2];
    logic [31:0] e_sc  [2];
    logic [31:0] e_xc  [2];

    task automatic step(input logic rst, input logic stall, input logic br, input logic j,
                        input logic [31:0] ba, input logic [31:0] jm);
        @(negedge Clk);
        Rst = rst; Stall = stall; Br_AND = br; JumpOr = j; Br_ADD = ba; JumpMux = jm;
        for (int k = 0; k < 2; k++) begin
            int fc;
            fc = (k == 0) ? 1 : 3;
            e_rpc[k] = m_pc[k];
`ifdef FETCH_SEQ_PERF_CNT_EN
            e_fc[k] = m_fetch[k]; e_sc[k] = m_stall[k]; e_xc[k] = m_flush[k];
`else
            e_fc[k] = 32'd0; e_sc[k] = 32'd0; e_xc[k] = 32'd0;
`endif
            e_en[k] = 1'b0; e_w[k] = 1'b0; e_f[k] = 1'b0; e_sel[k] = 2'b00;
            if (rst) begin
                e_f[k] = 1'b1;
                m_pv[k] = 1'b0; m_pc[k] = 32'd0; m_sq[k] = 0;
                m_fetch[k] = 32'd0; m_stall[k] = 32'd0; m_flush[k] = 32'd0;
            end else if (stall) begin
                m_stall[k] = m_stall[k] + 32'd1;
                if ((br || j) && !m_pv[k]) begin
                    m_pv[k] = 1'b1;
                    m_pc[k] = br ? ba : jm;
                end
            end else begin
                e_en[k] = 1'b1; e_w[k] = 1'b1;
                m_fetch[k] = m_fetch[k] + 32'd1;
                if (br || j || m_pv[k]) begin
                    e_sel[k] = br ? 2'b01 : (j ? 2'b10 : 2'b11);
                    e_f[k] = 1'b1;
                    m_pv[k] = 1'b0;
                    m_sq[k] = fc - 1;
                    m_flush[k] = m_flush[k] + 32'd1;
                end else if (m_sq[k] > 0) begin
                    e_f[k] = 1'b1;
                    m_sq[k] = m_sq[k] - 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1, 0, 0, 0, 0, 0);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (a_en[k] !== 1'b0 || a_f[k] !== 1'b1 || a_w[k] !== 1'b0 || a_sel[k] !== 2'b00) begin
                    n_fail++;
                    $display("FAIL reset_outputs[%0d]: got en=%b flush=%b write=%b sel=%b, expected en=0 flush=1 write=0 sel=00",
                             k, a_en[k], a_f[k], a_w[k], a_sel[k]);
                end
            end
        end
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (a_en[k] !== 1'b1 || a_sel[k] !== 2'b00 || a_f[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL free_run[%0d] cyc %0d: got en=%b sel=%b flush=%b, expected en=1 sel=00 flush=0",
                             k, c, a_en[k], a_sel[k], a_f[k]);
                end
            end
        end
        step(0, 0, 0, 0, 0, 0);
`ifdef FETCH_SEQ_PERF_CNT_EN
        n_tests++;
        if (d1_fc !== 32'd5) begin
            n_fail++;
            $display("FAIL fetch_cnt_after_5: got %0d expected 5", d1_fc);
        end
`else
        n_tests++;
        if (d1_fc !== 32'd0 || d3_sc !== 32'd0 || d3_xc !== 32'd0) begin
            n_fail++;
            $display("FAIL counters_disabled: got %0d/%0d/%0d expected 0/0/0", d1_fc, d3_sc, d3_xc);
        end
`endif
    endtask

    task automatic test_priority();
        step(0, 0, 1, 1, 32'h40, 32'h80);
        n_tests++;
        if (d1_sel !== 2'b01 || d1_f !== 1'b1 || d1_en !== 1'b1) begin
            n_fail++;
            $display("FAIL br_priority: got sel=%b flush=%b en=%b expected sel=01 flush=1 en=1", d1_sel, d1_f, d1_en);
        end
        step(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (d1_sel !== 2'b00 || d1_f !== 1'b0 || d3_f !== 1'b1) begin
            n_fail++;
            $display("FAIL after_redirect: got sel=%b flush1=%b flush3=%b expected sel=00 flush1=0 flush3=1",
                     d1_sel, d1_f, d3_f);
        end
        for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_pending();
        step(0, 1, 0, 1, 32'h0, 32'h100);
        n_tests++;
        if (d1_en !== 1'b0 || d1_f !== 1'b0 || d1_w !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_outputs: got en=%b flush=%b write=%b expected 0/0/0", d1_en, d1_f, d1_w);
        end
        step(0, 1, 1, 0, 32'h200, 32'h0);
        n_tests++;
        if (d1_rpc !== 32'h100 || d3_rpc !== 32'h100) begin
            n_fail++;
            $display("FAIL capture_jump: got %h/%h expected 00000100", d1_rpc, d3_rpc);
        end
        step(0, 1, 0, 0, 0, 0);
        n_tests++;
        if (d1_rpc !== 32'h100 || d1_en !== 1'b0) begin
            n_fail++;
            $display("FAIL oldest_wins: got rpc=%h en=%b expected rpc=00000100 en=0", d1_rpc, d1_en);
        end
        step(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (d1_sel !== 2'b11 || d1_f !== 1'b1 || d1_en !== 1'b1 || d3_sel !== 2'b11) begin
            n_fail++;
            $display("FAIL pending_issue: got sel=%b flush=%b en=%b sel3=%b expected 11/1/1/11",
                     d1_sel, d1_f, d1_en, d3_sel);
        end
        step(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (d1_sel !== 2'b00 || d1_f !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_cleared: got sel=%b flush=%b expected sel=00 flush=0", d1_sel, d1_f);
        end
        for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush3();
        logic [4:0] got;
        step(0, 0, 1, 0, 32'h40, 32'h0);
        got[0] = d3_f;
        step(0, 0, 0, 0, 0, 0);
        got[1] = d3_f;
        n_tests++;
        if (d1_f !== 1'b0) begin
            n_fail++;
            $display("FAIL flush1_single: got flush=%b expected 0", d1_f);
        end
        step(0, 1, 0, 0, 0, 0);
        got[2] = d3_f;
        step(0, 0, 0, 0, 0, 0);
        got[3] = d3_f;
        step(0, 0, 0, 0, 0, 0);
        got[4] = d3_f;
        n_tests++;
        if (got !== 5'b01011) begin
            n_fail++;
            $display("FAIL flush3_sequence: got %b expected 01011 (lsb first cycle)", got);
        end
    endtask

    task automatic test_reset_pending();
        step(0, 1, 0, 1, 32'h0, 32'h300);
        step(0, 1, 0, 0, 0, 0);
        n_tests++;
        if (d1_rpc !== 32'h300) begin
            n_fail++;
            $display("FAIL capture_before_reset: got %h expected 00000300", d1_rpc);
        end
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (d1_sel === 2'b11 || d3_sel === 2'b11 || d1_rpc !== 32'd0 || d1_f !== 1'b0 || d3_f !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discards_pending: got sel=%b/%b rpc=%h flush=%b/%b expected sel!=11 rpc=0 flush=0/0",
                     d1_sel, d3_sel, d1_rpc, d1_f, d3_f);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0), $urandom, $urandom);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (a_en[k] !== e_en[k] || a_w[k] !== e_w[k] || a_f[k] !== e_f[k] || a_sel[k] !== e_sel[k]) begin
                    n_fail++;
                    if (errs < 10)
                        $display("FAIL rand_ctrl[%0d] cyc %0d: got en=%b w=%b f=%b sel=%b expected en=%b w=%b f=%b sel=%b",
                                 k, c, a_en[k], a_w[k], a_f[k], a_sel[k], e_en[k], e_w[k], e_f[k], e_sel[k]);
                    errs++;
                end
                n_tests++;
                if (a_rpc[k] !== e_rpc[k] || a_fc[k] !== e_fc[k] || a_sc[k] !== e_sc[k] || a_xc[k] !== e_xc[k]) begin
                    n_fail++;
                    if (errs < 10)
                        $display("FAIL rand_regs[%0d] cyc %0d: got rpc=%h cnt=%0d/%0d/%0d expected rpc=%h cnt=%0d/%0d/%0d",
                                 k, c, a_rpc[k], a_fc[k], a_sc[k], a_xc[k], e_rpc[k], e_fc[k], e_sc[k], e_xc[k]);
                    errs++;
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pv[k] = 1'b0; m_pc[k] = 32'd0; m_sq[k] = 0;
            m_fetch[k] = 32'd0; m_stall[k] = 32'd0; m_flush[k] = 32'd0;
        end
        test_reset();
        test_priority();
        test_pending();
        test_flush3();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
